usb_bulk_in_ep: RTL

Bulk-IN endpoint stage that sits directly downstream of the packet layer's transaction outputs and upstream of its Tx inputs. It buffers a user AXI-Stream into packets of at most MAX_PACKET bytes. On each IN token addressed to ENDPOINT it replies with DATA0/DATA1 or a NAK. It manages the data toggle and replays the packet if the host does not ACK it.

---
 rtl/usb_bulk_in_ep.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/usb_bulk_in_ep.sv
// Bulk-IN endpoint: packs a byte stream into committed packets and answers
// IN tokens with DATA0/DATA1 or NAK. The packet stays queued until it is ACKed,
// so a lost or NAKed transfer is replayed unchanged on the next IN.
module usb_bulk_in_ep #(
  parameter int ENDPOINT       = 1,
  parameter int MAX_PACKET     = 512,
  parameter int DEPTH_LOG2     = 11,
  parameter int PKT_SLOTS_LOG2 = 2,
  parameter int ACK_TIMEOUT    = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  input  logic [7:0]                s_tdata,
  input  logic                      trn_start_i,
  input  logic [1:0]                trn_type_i,
  input  logic [3:0]                trn_endpoint_i,
  input  logic                      rx_trn_hsk_recv_i,
  input  logic [1:0]                rx_trn_hsk_type_i,
  output logic                      tx_trn_send_hsk_o,
  output logic [1:0]                tx_trn_hsk_type_o,
  input  logic                      tx_trn_hsk_sent_i,
  output logic                      tx_trn_data_start_o,
  output logic [1:0]                tx_trn_data_type_o,
  output logic [7:0]                tx_trn_data_o,
  output logic                      tx_trn_data_valid_o,
  input  logic                      tx_trn_data_ready_i,
  output logic                      tx_trn_data_last_o,
  output logic [PKT_SLOTS_LOG2:0]   pkt_count_o
);
  localparam int LW = $clog2(MAX_PACKET + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int DW = DEPTH_LOG2 + 1;
  localparam int PW = PKT_SLOTS_LOG2 + 1;

  typedef enum logic [2:0] {S_IDLE, S_NAK, S_START, S_DATA, S_WAIT_ACK} state_t;
  state_t r_state, w_next;

  logic [7:0]            r_mem   [2**DEPTH_LOG2];
  logic [LW-1:0]         r_lfifo [2**PKT_SLOTS_LOG2];
  logic [DW-1:0]         r_wr_ptr, r_rd_ptr, r_rd_shadow, w_used;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [PW-1:0]         r_lf_wr, r_lf_rd;
  logic [LW-1:0]         r_open, r_len, w_open_nx;
  logic [TW-1:0]         r_tmo;
  logic [7:0]            r_rdata;
  logic                  r_toggle, r_pend;
  logic                  w_wr_fire, w_commit, w_in_tok, w_rd_fire;
  logic                  w_load, w_ack, w_pend_set;

  assign w_used      = r_wr_ptr - r_rd_ptr;   // full is against the committed pointer
  assign pkt_count_o = r_lf_wr - r_lf_rd;
  assign s_tready    = rst_n && (w_used != DW'(2**DEPTH_LOG2))
                             && (pkt_count_o != PW'(2**PKT_SLOTS_LOG2));
  assign w_wr_fire   = s_tvalid && s_tready;
  assign w_open_nx   = r_open + LW'(1);
  assign w_commit    = w_wr_fire && (s_tlast || (w_open_nx == LW'(MAX_PACKET)));
  assign w_in_tok    = trn_start_i && (trn_type_i == 2'b10) && (trn_endpoint_i == 4'(ENDPOINT));
  assign w_rd_fire   = (r_state == S_DATA) && tx_trn_data_ready_i;

  assign tx_trn_hsk_type_o  = 2'b10;
  assign tx_trn_data_type_o = {r_toggle, 1'b0};
  assign tx_trn_data_o      = (r_state == S_DATA) ? r_rdata : 8'h00;

  // Read address runs one byte ahead on each accepted byte so DATA has no bubbles.
  assign w_rd_addr = w_load    ? r_rd_ptr[DEPTH_LOG2-1:0] :
                     w_rd_fire ? r_rd_shadow[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1) :
                                 r_rd_shadow[DEPTH_LOG2-1:0];

  // Data RAM write port.
  always_ff @(posedge clk)
    if (w_wr_fire) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= s_tdata;

  // Length FIFO write port.
  always_ff @(posedge clk)
    if (w_commit) r_lfifo[r_lf_wr[PKT_SLOTS_LOG2-1:0]] <= w_open_nx;

  // Registered RAM read: the prefetch byte presented in DATA.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rdata <= '0;
    else        r_rdata <= r_mem[w_rd_addr];

  // Write side: byte pointer, open-packet length and packet commit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_open   <= '0;
      r_lf_wr  <= '0;
    end else if (w_wr_fire) begin
      r_wr_ptr <= r_wr_ptr + DW'(1);
      r_open   <= w_commit ? '0 : w_open_nx;
      if (w_commit) r_lf_wr <= r_lf_wr + PW'(1);
    end

  // Read side: shadow pointer during transfer, commit on ACK, timeout, pending token.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_rd_shadow <= '0;
      r_lf_rd     <= '0;
      r_len       <= '0;
      r_toggle    <= 1'b0;
      r_tmo       <= '0;
      r_pend      <= 1'b0;
    end else begin
      if (w_load) begin
        r_len       <= r_lfifo[r_lf_rd[PKT_SLOTS_LOG2-1:0]];
        r_rd_shadow <= r_rd_ptr;
      end else if (w_rd_fire) begin
        r_len       <= r_len - LW'(1);
        r_rd_shadow <= r_rd_shadow + DW'(1);
      end
      if (w_ack) begin
        r_rd_ptr <= r_rd_shadow;
        r_lf_rd  <= r_lf_rd + PW'(1);
        r_toggle <= ~r_toggle;
      end
      r_tmo <= (r_state == S_WAIT_ACK) ? r_tmo + TW'(1) : '0;
      if (w_pend_set)             r_pend <= 1'b1;
      else if (r_state == S_IDLE) r_pend <= 1'b0;
    end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  // FSM next state and transaction outputs.
  always_comb begin
    w_next              = r_state;
    tx_trn_send_hsk_o   = 1'b0;
    tx_trn_data_start_o = 1'b0;
    tx_trn_data_valid_o = 1'b0;
    tx_trn_data_last_o  = 1'b0;
    w_load              = 1'b0;
    w_ack               = 1'b0;
    w_pend_set          = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_in_tok || r_pend) begin
          if (pkt_count_o == '0) w_next = S_NAK;
          else begin
            w_next = S_START;
            w_load = 1'b1;
          end
        end
      S_NAK: begin
        tx_trn_send_hsk_o = 1'b1;
        if (tx_trn_hsk_sent_i) w_next = S_IDLE;
      end
      S_START: begin
        tx_trn_data_start_o = 1'b1;
        if (r_len == '0) begin
          tx_trn_data_last_o = 1'b1;
          w_next = S_WAIT_ACK;
        end else w_next = S_DATA;
      end
      S_DATA: begin
        tx_trn_data_valid_o = 1'b1;
        tx_trn_data_last_o  = (r_len == LW'(1));
        if (tx_trn_data_ready_i && (r_len == LW'(1))) w_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (rx_trn_hsk_recv_i) begin
          w_next = S_IDLE;
          w_ack  = (rx_trn_hsk_type_i == 2'b00);
        end else if (r_tmo == TW'(ACK_TIMEOUT)) w_next = S_IDLE;
        // A fresh IN means the host never saw our data: rewind and serve it from IDLE.
        if (w_in_tok) begin
          w_next     = S_IDLE;
          w_pend_set = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
